// File: rtl/twpm_buf_pkg.sv
`default_nettype none
// ============================================================================
// twpm_buf_pkg : shared types and constants for the TPM data-buffer arbiter
// Rev 1.0
// ============================================================================
package twpm_buf_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int C_LANES    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_RDATA = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/twpm_rr_arb2.sv
`default_nettype none
// ============================================================================
// twpm_rr_arb2 : two-requester round-robin arbiter (bit 0 = host, bit 1 = MCU)
// Rev 1.0
// ============================================================================
module twpm_rr_arb2
    import twpm_buf_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_gnt_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    logic r_last_mcu;

    always_comb begin
        o_gnt = 2'b00;
        if (i_gnt_en) begin
            if (i_req == 2'b11) begin
                o_gnt = r_last_mcu ? 2'b01 : 2'b10;
            end else begin
                o_gnt = i_req;
            end
        end
    end

    // Resetting to MCU makes the host win the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_mcu <= 1'b1;
        end else if (o_gnt != 2'b00) begin
            r_last_mcu <= o_gnt[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/twpm_buf_arb.sv
`default_nettype none
// ============================================================================
// twpm_buf_arb : host(byte)/MCU(word) arbiter and width adapter for 512x32 RAM
// Rev 1.0
// ============================================================================
module twpm_buf_arb
    import twpm_buf_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
)
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              host_req_i,
    input  logic              host_we_i,
    input  logic [ADDR_W+1:0] host_addr_i,
    input  logic [7:0]        host_wdata_i,
    output logic [7:0]        host_rdata_o,
    output logic              host_ack_o,
    input  logic              mcu_req_i,
    input  logic              mcu_we_i,
    input  logic [ADDR_W-1:0] mcu_addr_i,
    input  logic [3:0]        mcu_sel_i,
    input  logic [31:0]       mcu_wdata_i,
    output logic [31:0]       mcu_rdata_o,
    output logic              mcu_ack_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [31:0]       ram_wd_o,
    output logic [3:0]        ram_wen_o,
    output logic              ram_wclk_en_o,
    output logic              ram_rclk_en_o,
    input  logic [31:0]       ram_rd_i
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_gnt_en;
    logic [1:0]          w_gnt;
    logic [3:0]          w_host_lane_oh;

    logic                r_owner_mcu;
    logic                r_we;
    logic [1:0]          r_lane;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [31:0]         r_ram_wd;
    logic [3:0]          r_ram_wen;
    logic                r_wclk_en;
    logic                r_rclk_en;
    logic [7:0]          r_host_rdata;
    logic [31:0]         r_mcu_rdata;

    twpm_rr_arb2 u_arb (
        .clk      (clk_i),
        .rst      (rst_i),
        .i_gnt_en (w_gnt_en),
        .i_req    ({mcu_req_i, host_req_i}),
        .o_gnt    (w_gnt)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_en       = 1'b0;
        w_host_lane_oh = 4'b0001 << host_addr_i[1:0];
        case (r_state)
            ST_IDLE: begin
                w_gnt_en = 1'b1;
                if (host_req_i || mcu_req_i) begin
                    w_state_nxt = ST_CMD;
                end
            end
            ST_CMD:   w_state_nxt = r_we ? ST_ACK : ST_RDATA;
            ST_RDATA: w_state_nxt = ST_ACK;
            ST_ACK:   w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // RAM command is registered at grant and held for exactly the CMD cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_owner_mcu <= 1'b0;
            r_we        <= 1'b0;
            r_lane      <= 2'd0;
            r_ram_addr  <= '0;
            r_ram_wd    <= '0;
            r_ram_wen   <= '0;
            r_wclk_en   <= 1'b0;
            r_rclk_en   <= 1'b0;
        end else if (w_gnt[1]) begin
            r_owner_mcu <= 1'b1;
            r_we        <= mcu_we_i;
            r_lane      <= 2'd0;
            r_ram_addr  <= mcu_addr_i;
            r_ram_wd    <= mcu_we_i ? mcu_wdata_i : 32'h0;
            r_ram_wen   <= mcu_we_i ? mcu_sel_i : 4'h0;
            r_wclk_en   <= mcu_we_i;
            r_rclk_en   <= ~mcu_we_i;
        end else if (w_gnt[0]) begin
            r_owner_mcu <= 1'b0;
            r_we        <= host_we_i;
            r_lane      <= host_addr_i[1:0];
            r_ram_addr  <= host_addr_i[ADDR_W+1:2];
            r_ram_wd    <= host_we_i ? {C_LANES{host_wdata_i}} : 32'h0;
            r_ram_wen   <= host_we_i ? w_host_lane_oh : 4'h0;
            r_wclk_en   <= host_we_i;
            r_rclk_en   <= ~host_we_i;
        end else if (r_state == ST_CMD) begin
            r_ram_addr  <= '0;
            r_ram_wd    <= '0;
            r_ram_wen   <= '0;
            r_wclk_en   <= 1'b0;
            r_rclk_en   <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_host_rdata <= '0;
            r_mcu_rdata  <= '0;
        end else if (r_state == ST_RDATA) begin
            if (r_owner_mcu) begin
                r_mcu_rdata <= ram_rd_i;
            end else begin
                r_host_rdata <= ram_rd_i[{r_lane, 3'b000} +: 8];
            end
        end
    end

    assign host_ack_o    = (r_state == ST_ACK) && !r_owner_mcu;
    assign mcu_ack_o     = (r_state == ST_ACK) &&  r_owner_mcu;
    assign host_rdata_o  = r_host_rdata;
    assign mcu_rdata_o   = r_mcu_rdata;
    assign ram_addr_o    = r_ram_addr;
    assign ram_wd_o      = r_ram_wd;
    assign ram_wen_o     = r_ram_wen;
    assign ram_wclk_en_o = r_wclk_en;
    assign ram_rclk_en_o = r_rclk_en;

endmodule
`default_nettype wire

// File: tb/tb_twpm_buf_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_twpm_buf_arb : self-checking bench with RAM model and byte-level reference
// Rev 1.0
// ============================================================================
module tb_twpm_buf_arb;

    localparam int ADDR_W = 9;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              host_req_i, host_we_i;
    logic [ADDR_W+1:0] host_addr_i;
    logic [7:0]        host_wdata_i, host_rdata_o;
    logic              host_ack_o;
    logic              mcu_req_i, mcu_we_i;
    logic [ADDR_W-1:0] mcu_addr_i;
    logic [3:0]        mcu_sel_i;
    logic [31:0]       mcu_wdata_i, mcu_rdata_o;
    logic              mcu_ack_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [31:0]       ram_wd_o;
    logic [3:0]        ram_wen_o;
    logic              ram_wclk_en_o, ram_rclk_en_o;
    logic [31:0]       ram_rd_i;
    logic              tb_clear;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] ram     [0:511];
    logic [7:0]  ref_mem [0:2047];
    bit          exp_last_mcu;

    always #5 clk_i = ~clk_i;

    twpm_buf_arb #(.ADDR_W(ADDR_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i),
        .host_wdata_i(host_wdata_i), .host_rdata_o(host_rdata_o), .host_ack_o(host_ack_o),
        .mcu_req_i(mcu_req_i), .mcu_we_i(mcu_we_i), .mcu_addr_i(mcu_addr_i),
        .mcu_sel_i(mcu_sel_i), .mcu_wdata_i(mcu_wdata_i), .mcu_rdata_o(mcu_rdata_o),
        .mcu_ack_o(mcu_ack_o), .ram_addr_o(ram_addr_o), .ram_wd_o(ram_wd_o),
        .ram_wen_o(ram_wen_o), .ram_wclk_en_o(ram_wclk_en_o), .ram_rclk_en_o(ram_rclk_en_o),
        .ram_rd_i(ram_rd_i)
    );

    // Single-port byte-enabled RAM with one-cycle registered read and no reset.
    always @(posedge clk_i) begin
        if (tb_clear) begin
            for (int i = 0; i < 512; i++) ram[i] <= '0;
            ram_rd_i <= '0;
        end else begin
            if (ram_wclk_en_o)
                for (int b = 0; b < 4; b++)
                    if (ram_wen_o[b]) ram[ram_addr_o][8*b +: 8] <= ram_wd_o[8*b +: 8];
            if (ram_rclk_en_o) ram_rd_i <= ram[ram_addr_o];
        end
    end

    function automatic logic [31:0] ref_word(input int w);
        return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
    endfunction

    task automatic ref_write(input bit port, input logic [10:0] addr,
                             input logic [31:0] wd, input logic [3:0] sel);
        if (port) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) ref_mem[4*int'(addr) + b] = wd[8*b +: 8];
        end else begin
            ref_mem[int'(addr)] = wd[7:0];
        end
    endtask

    task automatic do_reset(input bit clear);
        host_req_i = 0; host_we_i = 0; host_addr_i = '0; host_wdata_i = '0;
        mcu_req_i = 0; mcu_we_i = 0; mcu_addr_i = '0; mcu_sel_i = '0; mcu_wdata_i = '0;
        rst_i = 1; tb_clear = clear;
        if (clear) for (int i = 0; i < 2048; i++) ref_mem[i] = 8'h00;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 0; tb_clear = 0;
        exp_last_mcu = 1'b1;
    endtask

    // Single uncontested access; returns latency in cycles from request (grant edge = 1).
    task automatic access(input bit port, input bit we, input logic [10:0] addr,
                          input logic [31:0] wd, input logic [3:0] sel,
                          output logic [31:0] rd, output int lat);
        lat = -1; rd = '0;
        if (port) begin
            mcu_req_i = 1; mcu_we_i = we; mcu_addr_i = addr[8:0]; mcu_sel_i = sel; mcu_wdata_i = wd;
        end else begin
            host_req_i = 1; host_we_i = we; host_addr_i = addr; host_wdata_i = wd[7:0];
        end
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk_i); #1;
            if (port ? mcu_ack_o : host_ack_o) begin
                lat = c;
                rd  = port ? mcu_rdata_o : {24'h0, host_rdata_o};
                break;
            end
        end
        host_req_i = 0; mcu_req_i = 0;
        if (lat > 0) begin
            if (we) ref_write(port, addr, wd, sel);
            exp_last_mcu = port;
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        n_tests++;
        if ({host_ack_o, mcu_ack_o} !== 2'b00) begin
            n_fail++; $display("FAIL reset_ack: got %b want 00", {host_ack_o, mcu_ack_o});
        end
        n_tests++;
        if ({ram_addr_o, ram_wd_o, ram_wen_o, ram_wclk_en_o, ram_rclk_en_o} !== '0) begin
            n_fail++; $display("FAIL reset_ram: addr %h wd %h wen %b wen_clk %b ren_clk %b want all 0",
                               ram_addr_o, ram_wd_o, ram_wen_o, ram_wclk_en_o, ram_rclk_en_o);
        end
        n_tests++;
        if ({host_rdata_o, mcu_rdata_o} !== 40'h0) begin
            n_fail++; $display("FAIL reset_rdata: host %h mcu %h want 0", host_rdata_o, mcu_rdata_o);
        end
    endtask

    task automatic test_host_write();
        host_req_i = 1; host_we_i = 1; host_addr_i = 11'h013; host_wdata_i = 8'hA5;
        @(posedge clk_i); #1;
        n_tests++;
        if (ram_addr_o !== 9'h004 || ram_wen_o !== 4'b1000 || ram_wd_o !== 32'hA5A5A5A5 ||
            ram_wclk_en_o !== 1'b1 || ram_rclk_en_o !== 1'b0) begin
            n_fail++; $display("FAIL hw_cmd: addr %h wen %b wd %h we %b re %b want 004 1000 a5a5a5a5 1 0",
                               ram_addr_o, ram_wen_o, ram_wd_o, ram_wclk_en_o, ram_rclk_en_o);
        end
        @(posedge clk_i); #1;
        n_tests++;
        if (host_ack_o !== 1'b1 || mcu_ack_o !== 1'b0) begin
            n_fail++; $display("FAIL hw_ack: host %b mcu %b want 1 0", host_ack_o, mcu_ack_o);
        end
        host_req_i = 0;
        ref_write(1'b0, 11'h013, 32'hA5, 4'h0);
        exp_last_mcu = 1'b0;
        @(posedge clk_i); #1;
        n_tests++;
        if (host_ack_o !== 1'b0 || {ram_wen_o, ram_wclk_en_o, ram_rclk_en_o} !== '0) begin
            n_fail++; $display("FAIL hw_after: ack %b wen %b we %b re %b want all 0",
                               host_ack_o, ram_wen_o, ram_wclk_en_o, ram_rclk_en_o);
        end
    endtask

    task automatic test_mcu_write_host_read();
        logic [31:0] rd;
        int lat;
        access(1'b1, 1'b1, 11'h004, 32'h11223344, 4'b0011, rd, lat);
        n_tests++;
        if (lat !== 2) begin n_fail++; $display("FAIL mw_lat: got %0d want 2", lat); end
        access(1'b0, 1'b0, 11'h011, 32'h0, 4'h0, rd, lat);
        n_tests++;
        if (lat !== 3 || rd[7:0] !== 8'h33) begin
            n_fail++; $display("FAIL hr_data: lat %0d data %h want 3 33", lat, rd[7:0]);
        end
        access(1'b1, 1'b0, 11'h004, 32'h0, 4'h0, rd, lat);
        n_tests++;
        if (lat !== 3 || rd !== ref_word(4)) begin
            n_fail++; $display("FAIL mr_data: lat %0d data %h want 3 %h", lat, rd, ref_word(4));
        end
    endtask

    task automatic test_sel_zero();
        logic [31:0] rd;
        int lat;
        access(1'b1, 1'b1, 11'h008, 32'hCAFEF00D, 4'hF, rd, lat);
        mcu_req_i = 1; mcu_we_i = 1; mcu_addr_i = 9'h008; mcu_sel_i = 4'h0; mcu_wdata_i = 32'h12345678;
        @(posedge clk_i); #1;
        n_tests++;
        if (ram_wen_o !== 4'h0) begin n_fail++; $display("FAIL sel0_wen: got %b want 0000", ram_wen_o); end
        @(posedge clk_i); #1;
        n_tests++;
        if (mcu_ack_o !== 1'b1) begin n_fail++; $display("FAIL sel0_ack: got %b want 1", mcu_ack_o); end
        mcu_req_i = 0;
        exp_last_mcu = 1'b1;
        @(posedge clk_i); #1;
        access(1'b1, 1'b0, 11'h008, 32'h0, 4'h0, rd, lat);
        n_tests++;
        if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL sel0_keep: got %h want cafef00d", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int lat;
        bit seen;
        host_req_i = 1; host_we_i = 0; host_addr_i = 11'h020;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_i = 1; host_req_i = 0;
        @(posedge clk_i); #1;
        rst_i = 0;
        exp_last_mcu = 1'b1;
        n_tests++;
        if ({host_ack_o, mcu_ack_o, ram_addr_o, ram_wd_o, ram_wen_o, ram_wclk_en_o, ram_rclk_en_o,
             host_rdata_o, mcu_rdata_o} !== '0) begin
            n_fail++; $display("FAIL rstmid_out: ack %b%b addr %h wen %b hrd %h mrd %h want all 0",
                               host_ack_o, mcu_ack_o, ram_addr_o, ram_wen_o, host_rdata_o, mcu_rdata_o);
        end
        seen = 0;
        repeat (3) begin
            @(posedge clk_i); #1;
            if (host_ack_o || mcu_ack_o) seen = 1;
        end
        n_tests++;
        if (seen) begin n_fail++; $display("FAIL rstmid_noack: got ack after reset want none"); end
        access(1'b0, 1'b0, 11'h020, 32'h0, 4'h0, rd, lat);
        n_tests++;
        if (lat !== 3 || rd[7:0] !== 8'h0D) begin
            n_fail++; $display("FAIL rstmid_reissue: lat %0d data %h want 3 0d", lat, rd[7:0]);
        end
    endtask

    task automatic test_tie();
        bit order [0:2];
        int n;
        do_reset(1'b0);
        host_req_i = 1; host_we_i = 0; host_addr_i = 11'h013;
        mcu_req_i = 1; mcu_we_i = 0; mcu_addr_i = 9'h004; mcu_sel_i = 4'h0;
        n = 0;
        for (int c = 0; c < 40 && n < 3; c++) begin
            @(posedge clk_i); #1;
            if (host_ack_o || mcu_ack_o) begin
                order[n] = mcu_ack_o;
                n_tests++;
                if (host_ack_o && host_rdata_o !== ref_mem[11'h013]) begin
                    n_fail++; $display("FAIL tie_hdata: got %h want %h", host_rdata_o, ref_mem[11'h013]);
                end else if (mcu_ack_o && mcu_rdata_o !== ref_word(4)) begin
                    n_fail++; $display("FAIL tie_mdata: got %h want %h", mcu_rdata_o, ref_word(4));
                end
                n++;
                if (n == 3) begin host_req_i = 0; mcu_req_i = 0; end
            end
        end
        n_tests++;
        if (n != 3 || order[0] !== 1'b0 || order[1] !== 1'b1 || order[2] !== 1'b0) begin
            n_fail++; $display("FAIL tie_order: acks %0d order %b%b%b want 3 acks H M H (0 1 0)",
                               n, order[0], order[1], order[2]);
        end
        exp_last_mcu = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic test_continuous();
        logic        h_we, m_we;
        logic [10:0] h_addr;
        logic [8:0]  m_addr;
        logic [7:0]  h_wd;
        logic [31:0] m_wd;
        logic [3:0]  m_sel;
        bit          prev_ack, exp_owner;
        int          acks;
        h_we = 1'($urandom); h_addr = 11'($urandom_range(0, 31)); h_wd = 8'($urandom);
        m_we = 1'($urandom); m_addr = 9'($urandom_range(0, 7)); m_wd = $urandom; m_sel = 4'($urandom);
        host_req_i = 1; host_we_i = h_we; host_addr_i = h_addr; host_wdata_i = h_wd;
        mcu_req_i = 1; mcu_we_i = m_we; mcu_addr_i = m_addr; mcu_sel_i = m_sel; mcu_wdata_i = m_wd;
        acks = 0; prev_ack = 0;
        for (int c = 0; c < 200 && acks < 20; c++) begin
            @(posedge clk_i); #1;
            n_tests++;
            if (ram_wclk_en_o && ram_rclk_en_o) begin
                n_fail++; $display("FAIL cont_en_excl: wclk_en %b rclk_en %b want not both",
                                   ram_wclk_en_o, ram_rclk_en_o);
            end
            if (host_ack_o || mcu_ack_o) begin
                exp_owner = ~exp_last_mcu;
                n_tests++;
                if ((host_ack_o && mcu_ack_o) || prev_ack || mcu_ack_o !== exp_owner) begin
                    n_fail++; $display("FAIL cont_grant: ack %0d host %b mcu %b prev %b want owner %b single",
                                       acks, host_ack_o, mcu_ack_o, prev_ack, exp_owner);
                end
                exp_last_mcu = mcu_ack_o;
                if (host_ack_o) begin
                    if (h_we) ref_write(1'b0, h_addr, {24'h0, h_wd}, 4'h0);
                    else begin
                        n_tests++;
                        if (host_rdata_o !== ref_mem[int'(h_addr)]) begin
                            n_fail++; $display("FAIL cont_hrd: addr %h got %h want %h",
                                               h_addr, host_rdata_o, ref_mem[int'(h_addr)]);
                        end
                    end
                    h_we = 1'($urandom); h_addr = 11'($urandom_range(0, 31)); h_wd = 8'($urandom);
                    host_we_i = h_we; host_addr_i = h_addr; host_wdata_i = h_wd;
                end else begin
                    if (m_we) ref_write(1'b1, {2'b00, m_addr}, m_wd, m_sel);
                    else begin
                        n_tests++;
                        if (mcu_rdata_o !== ref_word(int'(m_addr))) begin
                            n_fail++; $display("FAIL cont_mrd: addr %h got %h want %h",
                                               m_addr, mcu_rdata_o, ref_word(int'(m_addr)));
                        end
                    end
                    m_we = 1'($urandom); m_addr = 9'($urandom_range(0, 7)); m_wd = $urandom;
                    m_sel = 4'($urandom);
                    mcu_we_i = m_we; mcu_addr_i = m_addr; mcu_sel_i = m_sel; mcu_wdata_i = m_wd;
                end
                acks++;
                prev_ack = 1;
            end else begin
                prev_ack = 0;
            end
        end
        host_req_i = 0; mcu_req_i = 0;
        n_tests++;
        if (acks != 20) begin n_fail++; $display("FAIL cont_count: got %0d acks want 20", acks); end
        @(posedge clk_i); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_host_write();
        test_mcu_write_host_read();
        test_sel_zero();
        test_reset_mid();
        test_tie();
        test_continuous();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
